// File: rtl/motion_update_dispatch.sv
// Motion update dispatch: walks every cell's position cache in z-fastest
// order, reads the particle count at address 0 and then every particle,
// and broadcasts each position together with the destination cell it
// now belongs to (with periodic wrap at the grid boundary).
module motion_update_dispatch #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 8,
    parameter int CELL_ID_WIDTH = 4,
    parameter int NUM_CELL_X    = 3,
    parameter int NUM_CELL_Y    = 3,
    parameter int NUM_CELL_Z    = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_start,
    output logic [3*CELL_ID_WIDTH-1:0] out_rd_cell_id,
    output logic [ADDR_WIDTH-1:0]      out_rd_address,
    output logic                       out_rden,
    input  logic [3*DATA_WIDTH-1:0]    in_particle_info,
    output logic [3*DATA_WIDTH-1:0]    out_data,
    output logic [3*CELL_ID_WIDTH-1:0] out_data_dst_cell,
    output logic                       out_data_valid,
    output logic                       out_motion_update_enable,
    output logic                       out_busy,
    output logic                       out_done
);

    localparam int CW = CELL_ID_WIDTH;
    localparam logic [CW-1:0] NX_C  = CW'(NUM_CELL_X);
    localparam logic [CW-1:0] NY_C  = CW'(NUM_CELL_Y);
    localparam logic [CW-1:0] NZ_C  = CW'(NUM_CELL_Z);
    localparam logic [CW-1:0] ONE_C = CW'(1);

    typedef enum logic [2:0] {
        IDLE,
        RD_NUM,
        CAP_NUM,
        RD_PART,
        DRAIN,
        NEXT_CELL,
        END_HOLD,
        DONE
    } state_e;

    state_e state_q, state_d;

    logic rst_meta_q, rst_sync_q;

    logic [CW-1:0]         cell_x_q, cell_y_q, cell_z_q;
    logic [ADDR_WIDTH-1:0] count_q;
    logic [ADDR_WIDTH-1:0] read_idx_q;
    logic                  part_pending_q;

    logic [3*DATA_WIDTH-1:0] data_q;
    logic [3*CW-1:0]         dst_q;
    logic                    valid_q;

    logic                  last_cell;
    logic [ADDR_WIDTH-1:0] num_readout;
    logic [3*CW-1:0]       dst_d;

    // Map one position component's cell index onto a 1-based destination
    // cell, folding indices past the grid edge back to the start.
    function automatic logic [CW-1:0] wrap_dst(input logic [CW-1:0] idx,
                                               input logic [CW-1:0] n);
        if (idx < n) begin
            return idx + ONE_C;
        end else begin
            return idx - n + ONE_C;
        end
    endfunction

    assign last_cell   = (cell_x_q == NX_C) && (cell_y_q == NY_C) && (cell_z_q == NZ_C);
    assign num_readout = in_particle_info[ADDR_WIDTH-1:0];

    // Destination cell of the particle currently on the cache readout.
    assign dst_d = {wrap_dst(in_particle_info[DATA_WIDTH-1 -: CW], NX_C),
                    wrap_dst(in_particle_info[2*DATA_WIDTH-1 -: CW], NY_C),
                    wrap_dst(in_particle_info[3*DATA_WIDTH-1 -: CW], NZ_C)};

    // Reset synchronizer: assertion takes effect immediately, release lines up with clk.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rst_meta_q <= 1'b0;
            rst_sync_q <= 1'b0;
        end else begin
            rst_meta_q <= 1'b1;
            rst_sync_q <= rst_meta_q;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_sync_q) begin
        if (!rst_sync_q) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic for the sweep sequencer.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (in_start) state_d = RD_NUM;
            RD_NUM:    state_d = CAP_NUM;
            CAP_NUM:   state_d = (num_readout == '0) ? NEXT_CELL : RD_PART;
            RD_PART:   if (read_idx_q == count_q) state_d = DRAIN;
            DRAIN:     state_d = NEXT_CELL;
            NEXT_CELL: state_d = last_cell ? END_HOLD : RD_NUM;
            END_HOLD:  state_d = DONE;
            DONE:      state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // Cache read port and sweep status outputs decoded from the state.
    always_comb begin
        out_rden                 = 1'b0;
        out_rd_address           = '0;
        out_motion_update_enable = 1'b0;
        out_done                 = 1'b0;
        case (state_q)
            RD_NUM: begin
                out_rden = 1'b1;
            end
            RD_PART: begin
                out_rden       = 1'b1;
                out_rd_address = read_idx_q;
            end
            default: ;
        endcase
        if (state_q != IDLE && state_q != DONE) begin
            out_motion_update_enable = 1'b1;
        end
        if (state_q == DONE) begin
            out_done = 1'b1;
        end
    end

    assign out_busy       = out_motion_update_enable;
    assign out_rd_cell_id = {cell_x_q, cell_y_q, cell_z_q};

    // Cell cursor, per-cell particle count and read index.
    always_ff @(posedge clk or negedge rst_sync_q) begin
        if (!rst_sync_q) begin
            cell_x_q   <= '0;
            cell_y_q   <= '0;
            cell_z_q   <= '0;
            count_q    <= '0;
            read_idx_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_start) begin
                        cell_x_q <= ONE_C;
                        cell_y_q <= ONE_C;
                        cell_z_q <= ONE_C;
                    end
                end
                CAP_NUM: begin
                    count_q    <= num_readout;
                    read_idx_q <= {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
                end
                RD_PART: begin
                    if (read_idx_q != count_q) begin
                        read_idx_q <= read_idx_q + 1'b1;
                    end
                end
                NEXT_CELL: begin
                    if (!last_cell) begin
                        if (cell_z_q != NZ_C) begin
                            cell_z_q <= cell_z_q + ONE_C;
                        end else begin
                            cell_z_q <= ONE_C;
                            if (cell_y_q != NY_C) begin
                                cell_y_q <= cell_y_q + ONE_C;
                            end else begin
                                cell_y_q <= ONE_C;
                                cell_x_q <= cell_x_q + ONE_C;
                            end
                        end
                    end
                end
                DONE: begin
                    cell_x_q <= '0;
                    cell_y_q <= '0;
                    cell_z_q <= '0;
                end
                default: ;
            endcase
        end
    end

    // Broadcast register: a particle read issued last cycle is on the readout
    // now and is captured with its destination; otherwise outputs are cleared.
    always_ff @(posedge clk or negedge rst_sync_q) begin
        if (!rst_sync_q) begin
            part_pending_q <= 1'b0;
            data_q         <= '0;
            dst_q          <= '0;
            valid_q        <= 1'b0;
        end else begin
            part_pending_q <= (state_q == RD_PART);
            if (part_pending_q) begin
                data_q  <= in_particle_info;
                dst_q   <= dst_d;
                valid_q <= 1'b1;
            end else begin
                data_q  <= '0;
                dst_q   <= '0;
                valid_q <= 1'b0;
            end
        end
    end

    assign out_data          = data_q;
    assign out_data_dst_cell = dst_q;
    assign out_data_valid    = valid_q;

endmodule

// File: tb/tb_motion_update_dispatch.sv
// Self-checking bench for motion_update_dispatch: models 27 position caches,
// predicts every broadcast beat and read from the cell contents, and checks
// the DUT through a scoreboard drained by a monitor process.
module tb_motion_update_dispatch;

    localparam int DW    = 32;
    localparam int AW    = 8;
    localparam int CW    = 4;
    localparam int NX    = 3;
    localparam int NY    = 3;
    localparam int NZ    = 3;
    localparam int NCELL = NX * NY * NZ;
    localparam int DEPTH = 8;

    logic            clk;
    logic            rst;
    logic            in_start;
    logic [3*CW-1:0] out_rd_cell_id;
    logic [AW-1:0]   out_rd_address;
    logic            out_rden;
    logic [3*DW-1:0] in_particle_info;
    logic [3*DW-1:0] out_data;
    logic [3*CW-1:0] out_data_dst_cell;
    logic            out_data_valid;
    logic            out_motion_update_enable;
    logic            out_busy;
    logic            out_done;

    typedef struct {
        logic [3*DW-1:0] data;
        logic [3*CW-1:0] dst;
    } beat_t;

    beat_t           expQ[$];
    longint          issueQ[$];
    logic [3*CW-1:0] cellQ[$];

    logic [3*DW-1:0] mem [NCELL][DEPTH];
    int              cnt [NCELL];

    int     errors = 0;
    int     checks = 0;
    longint cyc    = 0;

    logic            rspPend;
    logic [AW-1:0]   rspAddr;
    logic [3*CW-1:0] rspCell;

    motion_update_dispatch #(
        .DATA_WIDTH   (DW),
        .ADDR_WIDTH   (AW),
        .CELL_ID_WIDTH(CW),
        .NUM_CELL_X   (NX),
        .NUM_CELL_Y   (NY),
        .NUM_CELL_Z   (NZ)
    ) dut (
        .clk                     (clk),
        .rst                     (rst),
        .in_start                (in_start),
        .out_rd_cell_id          (out_rd_cell_id),
        .out_rd_address          (out_rd_address),
        .out_rden                (out_rden),
        .in_particle_info        (in_particle_info),
        .out_data                (out_data),
        .out_data_dst_cell       (out_data_dst_cell),
        .out_data_valid          (out_data_valid),
        .out_motion_update_enable(out_motion_update_enable),
        .out_busy                (out_busy),
        .out_done                (out_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count rising edges so read-to-beat latency can be measured.
    always @(posedge clk) cyc <= cyc + 1;

    // Compare one observed value against the bench's expectation.
    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit cellValid(input logic [3*CW-1:0] id);
        int x = int'(id[3*CW-1 -: CW]);
        int y = int'(id[2*CW-1 -: CW]);
        int z = int'(id[CW-1:0]);
        return (x >= 1 && x <= NX && y >= 1 && y <= NY && z >= 1 && z <= NZ);
    endfunction

    function automatic int cellIdx(input logic [3*CW-1:0] id);
        int x = int'(id[3*CW-1 -: CW]);
        int y = int'(id[2*CW-1 -: CW]);
        int z = int'(id[CW-1:0]);
        return ((x - 1) * NY + (y - 1)) * NZ + (z - 1);
    endfunction

    // Periodic destination of one axis from its 1-based cell count.
    function automatic logic [CW-1:0] dstOf(input int idx, input int n);
        int d = (idx < n) ? idx + 1 : idx - n + 1;
        return CW'(d);
    endfunction

    function automatic logic [3*CW-1:0] dstOfPos(input logic [3*DW-1:0] p);
        int ix = int'(p[DW-1 -: CW]);
        int iy = int'(p[2*DW-1 -: CW]);
        int iz = int'(p[3*DW-1 -: CW]);
        return {dstOf(ix, NX), dstOf(iy, NY), dstOf(iz, NZ)};
    endfunction

    function automatic logic [3*DW-1:0] makePos(input int ix, input int iy, input int iz);
        logic [DW-1:0] px, py, pz;
        px = {CW'(ix), (DW-CW)'($urandom)};
        py = {CW'(iy), (DW-CW)'($urandom)};
        pz = {CW'(iz), (DW-CW)'($urandom)};
        return {pz, py, px};
    endfunction

    // Cache contents: mode 0 all empty, 1 random 0..4, 2 directed, 3 random 1..4.
    task automatic fillMemory(input int mode);
        for (int c = 0; c < NCELL; c++) begin
            case (mode)
                0:       cnt[c] = 0;
                1:       cnt[c] = int'($urandom_range(0, 4));
                3:       cnt[c] = int'($urandom_range(1, 4));
                default: cnt[c] = 0;
            endcase
            for (int a = 1; a < DEPTH; a++) begin
                mem[c][a] = makePos(int'($urandom_range(0, 5)), int'($urandom_range(0, 5)),
                                    int'($urandom_range(0, 5)));
            end
        end
        if (mode == 2) begin
            cnt[0]    = 2;
            mem[0][1] = makePos(3, 1, 0);
            mem[0][2] = makePos(2, 4, 5);
            cnt[1]    = 1;
            mem[1][1] = makePos(0, 2, 3);
            cnt[NCELL-1] = 3;
            for (int a = 1; a <= 3; a++) mem[NCELL-1][a] = makePos(0, 0, 0);
        end
        for (int c = 0; c < NCELL; c++) begin
            mem[c][0]           = {$urandom, $urandom, $urandom};
            mem[c][0][AW-1:0]   = AW'(cnt[c]);
        end
    endtask

    // Push the whole expected sweep into the scoreboard; returns the
    // number of cycles the update enable should stay high.
    task automatic buildExpect(output int enCycles);
        beat_t b;
        int    c;
        enCycles = 1;
        for (int x = 1; x <= NX; x++)
            for (int y = 1; y <= NY; y++)
                for (int z = 1; z <= NZ; z++) begin
                    c = ((x - 1) * NY + (y - 1)) * NZ + (z - 1);
                    cellQ.push_back({CW'(x), CW'(y), CW'(z)});
                    for (int a = 1; a <= cnt[c]; a++) begin
                        b.data = mem[c][a];
                        b.dst  = dstOfPos(mem[c][a]);
                        expQ.push_back(b);
                    end
                    enCycles += (cnt[c] == 0) ? 3 : cnt[c] + 4;
                end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_rden"}, out_rden, 0);
        checkOutput({tag, "_addr"}, out_rd_address, 0);
        checkOutput({tag, "_cell"}, out_rd_cell_id, 0);
        checkOutput({tag, "_valid"}, out_data_valid, 0);
        checkOutput({tag, "_data"}, out_data, 0);
        checkOutput({tag, "_dst"}, out_data_dst_cell, 0);
        checkOutput({tag, "_enable"}, out_motion_update_enable, 0);
        checkOutput({tag, "_busy"}, out_busy, 0);
        checkOutput({tag, "_done"}, out_done, 0);
    endtask

    // Run one full sweep and check its envelope; optionally pulse in_start mid-sweep.
    task automatic applyStimulus(input string tag, input bit glitch);
        int expEn, enCycles, doneCnt, waitCyc, post;
        bit sawDone;
        enCycles = 0; doneCnt = 0; waitCyc = 0; post = 0; sawDone = 0;
        buildExpect(expEn);
        @(negedge clk);
        in_start = 1'b1;
        @(negedge clk);
        in_start = 1'b0;
        while (!(sawDone && post >= 3) && waitCyc < 3000) begin
            if (out_motion_update_enable) enCycles++;
            if (out_done) begin
                doneCnt++;
                sawDone = 1'b1;
                checkOutput({tag, "_enable_low_at_done"}, out_motion_update_enable, 0);
            end else if (sawDone) begin
                post++;
            end
            if (glitch && waitCyc == 5) in_start = 1'b1;
            if (waitCyc == 6) in_start = 1'b0;
            waitCyc++;
            @(negedge clk);
        end
        in_start = 1'b0;
        if (waitCyc >= 3000) checkOutput({tag, "_sweep_timeout"}, 1, 0);
        checkOutput({tag, "_enable_cycles"}, enCycles, expEn);
        checkOutput({tag, "_done_pulses"}, doneCnt, 1);
        checkOutput({tag, "_beats_left"}, expQ.size(), 0);
        checkOutput({tag, "_cells_left"}, cellQ.size(), 0);
        checkOutput({tag, "_issues_left"}, issueQ.size(), 0);
    endtask

    // Position cache model: answers a read one cycle after out_rden.
    initial begin
        in_particle_info = '0;
        forever begin
            @(negedge clk);
            rspPend = out_rden;
            rspAddr = out_rd_address;
            rspCell = out_rd_cell_id;
            @(posedge clk);
            #1;
            if (rspPend && cellValid(rspCell) && int'(rspAddr) < DEPTH)
                in_particle_info = mem[cellIdx(rspCell)][rspAddr];
            else
                in_particle_info = {$urandom, $urandom, $urandom};
        end
    end

    // Monitor: checks reads against the cell order and count, and pops the
    // scoreboard on every broadcast beat.
    always @(negedge clk) begin
        beat_t  e;
        longint iss;
        if (rst === 1'b1) begin
            if (out_rden) begin
                if (out_rd_address == '0) begin
                    if (cellQ.size() == 0) checkOutput("unexpected_count_read", 1, 0);
                    else checkOutput("rd_cell_id", out_rd_cell_id, cellQ.pop_front());
                end else begin
                    checkOutput("rd_addr_within_count",
                                cellValid(out_rd_cell_id) &&
                                (int'(out_rd_address) <= cnt[cellIdx(out_rd_cell_id)]), 1);
                    issueQ.push_back(cyc);
                end
            end
            if (out_data_valid) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_beat", 1, 0);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("beat_data", out_data, e.data);
                    checkOutput("beat_dst", out_data_dst_cell, e.dst);
                end
                if (issueQ.size() == 0) begin
                    checkOutput("beat_without_read", 1, 0);
                end else begin
                    iss = issueQ.pop_front();
                    checkOutput("beat_latency", cyc - iss, 2);
                end
            end else begin
                checkOutput("idle_data_zero", out_data, 0);
                checkOutput("idle_dst_zero", out_data_dst_cell, 0);
            end
            checkOutput("busy_eq_enable", out_busy, out_motion_update_enable);
        end
    end

    initial begin
        int bad;
        int waitCyc;
        int dummy;
        rst      = 1'b0;
        in_start = 1'b0;
        #3;
        checkAllZero("reset");
        repeat (3) @(negedge clk);
        rst = 1'b1;

        bad = 0;
        repeat (8) begin
            @(negedge clk);
            if (out_rden || out_data_valid || out_motion_update_enable) bad++;
        end
        checkOutput("quiet_after_reset", bad, 0);

        fillMemory(0);
        applyStimulus("all_empty", 1'b0);

        fillMemory(2);
        applyStimulus("directed", 1'b0);

        fillMemory(1);
        applyStimulus("random_a", 1'b0);
        fillMemory(1);
        applyStimulus("random_glitch", 1'b1);

        // Reset pulled in the middle of a particle read burst.
        fillMemory(3);
        buildExpect(dummy);
        @(negedge clk);
        in_start = 1'b1;
        @(negedge clk);
        in_start = 1'b0;
        waitCyc = 0;
        while (!(out_rden && out_rd_address != '0) && waitCyc < 100) begin
            @(negedge clk);
            waitCyc++;
        end
        if (waitCyc >= 100) checkOutput("wait_rd_part_timeout", 1, 0);
        #2;
        rst = 1'b0;
        #1;
        checkAllZero("mid_reset");
        expQ.delete();
        issueQ.delete();
        cellQ.delete();
        repeat (3) @(negedge clk);
        checkAllZero("mid_reset_held");
        rst = 1'b1;
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (out_rden || out_data_valid || out_motion_update_enable || out_done) bad++;
        end
        checkOutput("quiet_after_mid_reset", bad, 0);

        fillMemory(1);
        applyStimulus("after_reset", 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
